ws2812_frame_scheduler: RTL and testbench



---
 rtl/ws2812_frame_scheduler_pkg.sv | 39 +++
 rtl/ws2812_pixel_scale.sv | 25 ++
 rtl/ws2812_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_ws2812_frame_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_frame_scheduler_pkg.sv
// Shared definitions for the WS2812 frame scheduler: FSM states, output color
// order, timing formulas and the per-channel brightness scale.
package ws2812_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_e;

    typedef enum logic [0:0] {
        ORDER_RGB,
        ORDER_GRB
    } color_order_e;

    localparam color_order_e COLOR_ORDER = ORDER_GRB;

    // 64-bit product keeps us * f_clk from overflowing for fast clocks.
    function automatic int unsigned treset_cycles(input int unsigned f_clk,
                                                  input int unsigned us);
        return 32'((64'(us) * 64'(f_clk)) / 64'd1_000_000);
    endfunction

    function automatic int unsigned refresh_cycles(input int unsigned f_clk,
                                                   input int unsigned hz);
        return (hz == 0) ? 1 : f_clk / hz;
    endfunction

    function automatic logic [7:0] scale8(input logic [7:0] c,
                                          input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/ws2812_pixel_scale.sv
// Combinational brightness scaling of an {R,G,B} pixel, reordered into the
// wire order expected by the LED chain.
module ws2812_pixel_scale
    import ws2812_frame_scheduler_pkg::*;
(
    input  logic [23:0] Pixel_In,
    input  logic [7:0]  Brightness,
    output logic [23:0] Pixel_Out
);

    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    always_comb begin
        red   = scale8(Pixel_In[23:16], Brightness);
        green = scale8(Pixel_In[15:8],  Brightness);
        blue  = scale8(Pixel_In[7:0],   Brightness);
        case (COLOR_ORDER)
            ORDER_GRB: Pixel_Out = {green, red, blue};
            default:   Pixel_Out = {red, green, blue};
        endcase
    end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler for a WS2812 chain: fetches pixels, scales and reorders them,
// feeds an external serializer one pixel at a time and inserts the latch gap.
module ws2812_frame_scheduler
    import ws2812_frame_scheduler_pkg::*;
#(
    parameter int unsigned F_CLK      = 12_000_000,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned TRESET_US  = 60,
    parameter int unsigned REFRESH_HZ = 30
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Auto_En,
    input  logic [ADDR_W:0]   Num_Pixels,
    input  logic [7:0]        Brightness,
    output logic              Pix_Req,
    output logic [ADDR_W-1:0] Pix_Addr,
    input  logic [23:0]       Pix_Data,
    input  logic              Pix_Valid,
    output logic              Ser_Load,
    output logic [23:0]       Ser_Data,
    input  logic              Ser_Busy,
    input  logic              Ser_Done,
    output logic              Busy,
    output logic              Frame_Done,
    output logic              Underrun
);

    localparam int unsigned MAX_PIXELS  = 2 ** ADDR_W;
    localparam int unsigned TRESET      = treset_cycles(F_CLK, TRESET_US);
    localparam int unsigned LATCH_CYC   = (TRESET == 0) ? 1 : TRESET;
    localparam int unsigned REFRESH_CYC = refresh_cycles(F_CLK, REFRESH_HZ);
    localparam int unsigned CW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam int unsigned RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    state_e          state_q;
    state_e          state_nxt;
    logic [ADDR_W:0] num_q;
    logic [ADDR_W:0] idx_q;
    logic [ADDR_W:0] num_clamped;
    logic [7:0]      bright_q;
    logic [23:0]     pf_data_q;
    logic            pf_valid_q;
    logic [23:0]     scaled;
    logic [CW-1:0]   latch_cnt_q;
    logic [RW-1:0]   ref_cnt_q;
    logic            refresh_wrap;
    logic            tick;
    logic            frame_start;
    logic            more_px;
    logic            fetching;
    logic            capture;

    assign num_clamped  = (Num_Pixels > (ADDR_W+1)'(MAX_PIXELS)) ?
                          (ADDR_W+1)'(MAX_PIXELS) : Num_Pixels;
    assign refresh_wrap = (ref_cnt_q == RW'(REFRESH_CYC - 1));
    assign tick         = Auto_En && refresh_wrap;
    assign frame_start  = (state_q == ST_IDLE) && (Start || tick);
    assign more_px      = (idx_q < num_q);
    // The pending fetch always targets idx_q: the prefetch slot holds pixel
    // idx_q once valid, and idx_q only advances when that slot is loaded.
    assign fetching     = ((state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                           (state_q == ST_SHIFT)) && !pf_valid_q && more_px;
    assign capture      = fetching && Pix_Valid;

    ws2812_pixel_scale u_scale (
        .Pixel_In   (Pix_Data),
        .Brightness (bright_q),
        .Pixel_Out  (scaled)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ref_cnt_q <= '0;
        end else if (!Auto_En || refresh_wrap) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = (num_clamped == '0) ? ST_LATCH : ST_FETCH;
                end
            end
            ST_FETCH: if (capture) state_nxt = ST_LOAD;
            ST_LOAD:  if (pf_valid_q && !Ser_Busy) state_nxt = ST_SHIFT;
            ST_SHIFT: if (Ser_Done) state_nxt = more_px ? ST_LOAD : ST_LATCH;
            ST_LATCH: if (latch_cnt_q == CW'(LATCH_CYC - 1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy       = (state_q != ST_IDLE);
        Pix_Req    = fetching;
        Ser_Load   = (state_q == ST_LOAD) && pf_valid_q && !Ser_Busy;
        Frame_Done = (state_q == ST_DONE);
        Underrun   = (state_q == ST_SHIFT) && Ser_Done && more_px && !pf_valid_q;
        Pix_Addr   = idx_q[ADDR_W-1:0];
        Ser_Data   = pf_data_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            num_q      <= '0;
            bright_q   <= '0;
            idx_q      <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
        end else if (frame_start) begin
            num_q      <= num_clamped;
            bright_q   <= Brightness;
            idx_q      <= '0;
            pf_valid_q <= 1'b0;
        end else begin
            if (capture) begin
                pf_data_q  <= scaled;
                pf_valid_q <= 1'b1;
            end
            if (Ser_Load) begin
                pf_valid_q <= 1'b0;
                idx_q      <= idx_q + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            latch_cnt_q <= '0;
        end else if (state_q == ST_LATCH) begin
            latch_cnt_q <= latch_cnt_q + CW'(1);
        end else begin
            latch_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench for ws2812_frame_scheduler with behavioural pixel memory
// and serializer models; expected serializer words flow through a scoreboard.
module tb_ws2812_frame_scheduler;

    localparam int unsigned ADDR_W  = 8;
    localparam int          LATCH_GAP = 720 + 1;
    localparam int          PERIOD  = 5000;

    typedef struct packed {
        logic [23:0] pix;
        logic [7:0]  bri;
        logic [23:0] exp;
    } vec_t;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Start;
    logic              Auto_En;
    logic [ADDR_W:0]   Num_Pixels;
    logic [7:0]        Brightness;
    logic              Pix_Req;
    logic [ADDR_W-1:0] Pix_Addr;
    logic [23:0]       Pix_Data;
    logic              Pix_Valid;
    logic              Ser_Load;
    logic [23:0]       Ser_Data;
    logic              Ser_Busy;
    logic              Ser_Done;
    logic              Busy;
    logic              Frame_Done;
    logic              Underrun;

    ws2812_frame_scheduler #(
        .F_CLK      (12_000_000),
        .ADDR_W     (ADDR_W),
        .TRESET_US  (60),
        .REFRESH_HZ (2400)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .Auto_En    (Auto_En),
        .Num_Pixels (Num_Pixels),
        .Brightness (Brightness),
        .Pix_Req    (Pix_Req),
        .Pix_Addr   (Pix_Addr),
        .Pix_Data   (Pix_Data),
        .Pix_Valid  (Pix_Valid),
        .Ser_Load   (Ser_Load),
        .Ser_Data   (Ser_Data),
        .Ser_Busy   (Ser_Busy),
        .Ser_Done   (Ser_Done),
        .Busy       (Busy),
        .Frame_Done (Frame_Done),
        .Underrun   (Underrun)
    );

    initial forever #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_wait = 1;
    int          ser_cyc = 24;
    logic [23:0] mem [0:255];
    logic [23:0] sb [$];
    int          load_cnt = 0;
    int          underrun_cnt = 0;
    int          req_cnt = 0;
    int          frame_cnt = 0;
    int          addr_err = 0;
    int          last_sd_cyc = 0;
    int          fd_cyc = 0;
    int          start_cyc = 0;
    vec_t        vecs [10];

    initial forever @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] ref_pix(input logic [23:0] p, input logic [7:0] b);
        int unsigned k;
        int unsigned r;
        int unsigned g;
        int unsigned bl;
        k  = int'(b) + 1;
        r  = (int'(p[23:16]) * k) / 256;
        g  = (int'(p[15:8])  * k) / 256;
        bl = (int'(p[7:0])   * k) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    // Pixel memory: answers a request mem_wait cycles after it first appears.
    initial begin
        int  mwait;
        logic req;
        logic [ADDR_W-1:0] addr;
        Pix_Valid = 1'b0;
        Pix_Data  = '0;
        mwait     = 0;
        forever begin
            @(negedge Clk);
            req  = Pix_Req;
            addr = Pix_Addr;
            @(posedge Clk);
            #1;
            if (Pix_Valid) begin
                Pix_Valid = 1'b0;
                mwait     = 0;
            end else if (req) begin
                if (mwait >= mem_wait) begin
                    Pix_Valid = 1'b1;
                    Pix_Data  = mem[addr];
                end else begin
                    mwait++;
                end
            end else begin
                mwait = 0;
            end
        end
    end

    // Serializer: busy for ser_cyc cycles after a load, then a one-cycle done.
    initial begin
        int   cnt;
        logic load_seen;
        Ser_Busy = 1'b0;
        Ser_Done = 1'b0;
        cnt      = 0;
        forever begin
            @(negedge Clk);
            load_seen = Ser_Load;
            @(posedge Clk);
            #1;
            Ser_Done = 1'b0;
            if (load_seen) begin
                Ser_Busy = 1'b1;
                cnt      = ser_cyc;
            end else if (Ser_Busy) begin
                if (cnt <= 1) begin
                    Ser_Busy = 1'b0;
                    Ser_Done = 1'b1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        logic prev_req;
        logic prev_val;
        logic [ADDR_W-1:0] prev_addr;
        prev_req  = 1'b0;
        prev_val  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge Clk);
            if (Reset_n === 1'b1) begin
                if (Ser_Load) begin
                    load_cnt++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ser_data_unexpected actual=%06h required=no_load", Ser_Data);
                    end else begin
                        chk("ser_data", 64'(Ser_Data), 64'(sb.pop_front()));
                    end
                end
                if (Ser_Done)   last_sd_cyc = cyc;
                if (Frame_Done) begin
                    fd_cyc = cyc;
                    frame_cnt++;
                end
                if (Underrun) underrun_cnt++;
                if (Pix_Req)  req_cnt++;
                if (prev_req && !prev_val && Pix_Req && Pix_Addr != prev_addr) addr_err++;
            end
            prev_req  = Pix_Req & (Reset_n === 1'b1);
            prev_val  = Pix_Valid;
            prev_addr = Pix_Addr;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic pulse_start();
        @(posedge Clk);
        #1;
        Start     = 1'b1;
        start_cyc = cyc;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_frame(input int limit);
        int f0;
        int k;
        f0 = frame_cnt;
        k  = 0;
        while (frame_cnt == f0 && k < limit) begin
            @(negedge Clk);
            k++;
        end
        if (frame_cnt == f0) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout actual=none required=Frame_Done within %0d cycles", limit);
        end
    endtask

    task automatic wait_loads(input int n, input int limit);
        int k;
        k = 0;
        while (load_cnt < n && k < limit) begin
            @(negedge Clk);
            k++;
        end
        if (load_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL load_timeout actual=%0d required=%0d", load_cnt, n);
        end
    endtask

    task automatic run_frame(input int n, input logic [7:0] bri, input int limit);
        Num_Pixels = (ADDR_W+1)'(n);
        Brightness = bri;
        pulse_start();
        wait_frame(limit);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int f;
        int fd_a;
        int fd_b;
        Reset_n    = 1'b0;
        Start      = 1'b0;
        Auto_En    = 1'b0;
        Num_Pixels = '0;
        Brightness = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        vecs[0] = '{24'hFF0000, 8'd255, 24'h00FF00};
        vecs[1] = '{24'h00FF00, 8'd255, 24'hFF0000};
        vecs[2] = '{24'h0000FF, 8'd255, 24'h0000FF};
        vecs[3] = '{24'h804020, 8'd127, 24'h204010};
        vecs[4] = '{24'h804020, 8'd0,   24'h000000};
        vecs[5] = '{24'hFFFFFF, 8'd0,   24'h000000};
        vecs[6] = '{24'hFFFFFF, 8'd127, 24'h7F7F7F};
        vecs[7] = '{24'h123456, 8'd255, 24'h341256};
        vecs[8] = '{24'h010101, 8'd254, 24'h000000};
        vecs[9] = '{24'hFF8001, 8'd1,   24'h010100};

        wait_cycles(3);
        chk("reset_outputs", 64'({Pix_Req, Pix_Addr, Ser_Load, Ser_Data, Busy, Frame_Done, Underrun}), 64'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        wait_cycles(20);
        chk("idle_after_reset", 64'({Busy, Pix_Req}), 64'd0);

        for (int i = 0; i < 10; i++) begin
            mem[0] = vecs[i].pix;
            sb.push_back(vecs[i].exp);
            run_frame(1, vecs[i].bri, 3000);
        end

        // Three-pixel frame with an ignored Start while busy.
        mem[0] = 24'hFF0000;
        mem[1] = 24'h00FF00;
        mem[2] = 24'h0000FF;
        sb.push_back(24'h00FF00);
        sb.push_back(24'hFF0000);
        sb.push_back(24'h0000FF);
        load_cnt   = 0;
        Num_Pixels = 9'd3;
        Brightness = 8'd255;
        pulse_start();
        wait_loads(1, 500);
        pulse_start();
        wait_frame(3000);
        chk("latch_gap", 64'(fd_cyc - last_sd_cyc), 64'(LATCH_GAP));
        chk("loads_3px", 64'(load_cnt), 64'd3);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        f = frame_cnt;
        wait_cycles(900);
        chk("no_second_frame", 64'(frame_cnt - f), 64'd0);
        chk("idle_after_frame", 64'(Busy), 64'd0);

        // Slow memory: every pixel after the first misses its slot.
        mem[0] = 24'h112233;
        mem[1] = 24'h445566;
        mem[2] = 24'h778899;
        sb.push_back(24'h221133);
        sb.push_back(24'h554466);
        sb.push_back(24'h887799);
        mem_wait     = ser_cyc + 40;
        underrun_cnt = 0;
        load_cnt     = 0;
        run_frame(3, 8'd255, 3000);
        chk("underrun_count", 64'(underrun_cnt), 64'd2);
        chk("underrun_loads", 64'(load_cnt), 64'd3);
        mem_wait = 1;

        req_cnt  = 0;
        load_cnt = 0;
        run_frame(0, 8'd255, 2000);
        chk("zero_px_latency", 64'(fd_cyc - start_cyc), 64'(LATCH_GAP));
        chk("zero_px_no_req", 64'(req_cnt), 64'd0);
        chk("zero_px_no_load", 64'(load_cnt), 64'd0);

        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
            sb.push_back(ref_pix(mem[i], 8'd200));
        end
        load_cnt = 0;
        run_frame(300, 8'd200, 20000);
        chk("clamp_loads", 64'(load_cnt), 64'd256);
        chk("addr_stable", 64'(addr_err), 64'd0);

        // Auto refresh with two pixels per frame.
        mem[0] = 24'hA0B0C0;
        mem[1] = 24'h0F1E2D;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ref_pix(24'hA0B0C0, 8'd99));
            sb.push_back(ref_pix(24'h0F1E2D, 8'd99));
        end
        Num_Pixels = 9'd2;
        Brightness = 8'd99;
        @(posedge Clk);
        #1;
        Auto_En = 1'b1;
        wait_frame(8000);
        fd_a = fd_cyc;
        wait_frame(8000);
        fd_b = fd_cyc;
        chk("refresh_period_1", 64'(fd_b - fd_a), 64'(PERIOD));
        wait_frame(8000);
        chk("refresh_period_2", 64'(fd_cyc - fd_b), 64'(PERIOD));
        @(posedge Clk);
        #1;
        Auto_En = 1'b0;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of a frame.
        mem[0] = 24'hFF0000;
        mem[1] = 24'h00FF00;
        mem[2] = 24'h0000FF;
        sb.push_back(24'h00FF00);
        sb.push_back(24'hFF0000);
        sb.push_back(24'h0000FF);
        load_cnt   = 0;
        Num_Pixels = 9'd3;
        Brightness = 8'd255;
        pulse_start();
        wait_loads(2, 1000);
        wait_cycles(3);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("reset_async_outputs", 64'({Pix_Req, Pix_Addr, Ser_Load, Ser_Data, Busy, Frame_Done, Underrun}), 64'd0);
        f = frame_cnt;
        sb.delete();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        wait_cycles(1000);
        chk("no_frame_after_reset", 64'(frame_cnt - f), 64'd0);
        chk("idle_after_reset_release", 64'(Busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
